// File: rtl/fta_to_wb_bridge_if.sv
// FTA bus bundle: a requester drives req_*, a responder drives resp_*.
interface fta_bus_interface #(
  parameter int WID  = 256,
  parameter int TIDW = 8
);
  logic             req_cyc;
  logic             req_we;
  logic [WID/8-1:0] req_sel;
  logic [31:0]      req_adr;
  logic [WID-1:0]   req_data1;
  logic [TIDW-1:0]  req_tid;

  logic             resp_ack;
  logic             resp_err;
  logic             resp_rty;
  logic             resp_stall;
  logic [WID-1:0]   resp_dat;
  logic [TIDW-1:0]  resp_tid;
  logic [31:0]      resp_adr;

  modport slave (
    input  req_cyc, req_we, req_sel, req_adr, req_data1, req_tid,
    output resp_ack, resp_err, resp_rty, resp_stall, resp_dat, resp_tid, resp_adr
  );

  modport master (
    output req_cyc, req_we, req_sel, req_adr, req_data1, req_tid,
    input  resp_ack, resp_err, resp_rty, resp_stall, resp_dat, resp_tid, resp_adr
  );
endinterface

// File: rtl/fta_to_wb_bridge.sv
// FTA responder to Wishbone master bridge: requests are queued in a small FIFO and
// replayed one at a time as Wishbone cycles, each producing a single response pulse.
module fta_to_wb_bridge #(
  parameter int WID   = 256,
  parameter int DEPTH = 4,
  parameter int TMO   = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fta_bus_interface.slave  fta_i,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [WID/8-1:0] sel_o,
  output logic [31:0]      adr_o,
  output logic [WID-1:0]   dat_o,
  input  logic             ack_i,
  input  logic             err_i,
  input  logic [WID-1:0]   dat_i
);
  localparam int SW   = WID / 8;
  localparam int TIDW = 8;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = ($clog2(TMO + 1) > 8) ? $clog2(TMO + 1) : 8;
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   STALL_CNT = (AW + 1)'(DEPTH - 1);
  localparam logic [CW-1:0] TMO_CNT   = CW'(TMO);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic            we;
    logic [SW-1:0]   sel;
    logic [31:0]     adr;
    logic [WID-1:0]  data;
    logic [TIDW-1:0] tid;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          req_entry;
  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  entry_t          cur_q, cur_d;
  logic            cyc_q, cyc_d, we_q, we_d;
  logic            ack_q, ack_d, err_q, err_d, rty_q, rty_d;
  logic [WID-1:0]  rdat_q, rdat_d;
  logic [TIDW-1:0] rtid_q, rtid_d;
  logic [31:0]     radr_q, radr_d;
  logic            full, empty, push, pop;

  assign req_entry = {fta_i.req_we, fta_i.req_sel, fta_i.req_adr, fta_i.req_data1, fta_i.req_tid};
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign push      = fta_i.req_cyc && !full;
  assign pop       = (state_q == IDLE) && !empty;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= req_entry;
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    tmo_d    = tmo_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rty_d    = fta_i.req_cyc && full;
    rdat_d   = '0;
    rtid_d   = '0;
    radr_d   = '0;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          cur_d   = mem_q[rd_ptr_q];
          cyc_d   = 1'b1;
          we_d    = mem_q[rd_ptr_q].we;
          tmo_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // An ack arriving on the timeout clock still counts as a normal ack.
        if (ack_i || err_i || (tmo_q == TMO_CNT)) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          rtid_d  = cur_q.tid;
          radr_d  = cur_q.adr;
          state_d = RESP;
          if (ack_i && !err_i) begin
            ack_d = 1'b1;
            if (!cur_q.we) rdat_d = dat_i;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tmo_q    <= '0;
      cur_q    <= '0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rty_q    <= 1'b0;
      rdat_q   <= '0;
      rtid_q   <= '0;
      radr_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tmo_q    <= tmo_d;
      cur_q    <= cur_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rty_q    <= rty_d;
      rdat_q   <= rdat_d;
      rtid_q   <= rtid_d;
      radr_q   <= radr_d;
    end
  end

  assign cyc_o = cyc_q;
  assign stb_o = cyc_q;
  assign we_o  = we_q;
  assign sel_o = cur_q.sel;
  assign adr_o = cur_q.adr;
  assign dat_o = cur_q.data;

  assign fta_i.resp_ack   = ack_q;
  assign fta_i.resp_err   = err_q;
  assign fta_i.resp_rty   = rty_q;
  assign fta_i.resp_stall = (count_q >= STALL_CNT);
  assign fta_i.resp_dat   = rdat_q;
  assign fta_i.resp_tid   = rtid_q;
  assign fta_i.resp_adr   = radr_q;
endmodule

// File: tb/tb_fta_to_wb_bridge.sv
// Bench for fta_to_wb_bridge: queue-based reference model checked every clock, a vector
// table of single transactions, directed backpressure/reset sequences and random traffic.
module tb_fta_to_wb_bridge;
  localparam int WID = 64, DEPTH = 4, TMO = 20, SW = WID / 8;

  logic           clk = 1'b0;
  logic           rst, ack_i, err_i;
  logic [WID-1:0] dat_i;
  logic           cyc_o, stb_o, we_o;
  logic [SW-1:0]  sel_o;
  logic [31:0]    adr_o;
  logic [WID-1:0] dat_o;
  int             n_tests = 0, n_fail = 0;

  fta_bus_interface #(.WID(WID)) bus ();

  fta_to_wb_bridge #(.WID(WID), .DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .fta_i(bus),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o),
    .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending requests plus the one being served.
  typedef struct packed {
    logic           we;
    logic [SW-1:0]  sel;
    logic [31:0]    adr;
    logic [WID-1:0] data;
    logic [7:0]     tid;
  } ment_t;

  ment_t          mq[$];
  ment_t          mcur;
  bit             m_busy, m_show;
  int             m_elapsed;
  logic           e_cyc, e_we, e_ack, e_err, e_rty, e_stall;
  logic [WID-1:0] e_rdat;
  logic [7:0]     e_rtid;
  logic [31:0]    e_radr;

  task automatic model_step();
    bit full;
    full   = (mq.size() == DEPTH);
    e_ack  = 1'b0;
    e_err  = 1'b0;
    e_rdat = '0;
    e_rtid = '0;
    e_radr = '0;
    if (rst) begin
      mq.delete();
      mcur = '0; m_busy = 0; m_show = 0; m_elapsed = 0;
      e_cyc = 1'b0; e_we = 1'b0; e_rty = 1'b0; e_stall = 1'b0;
    end else begin
      e_rty = bus.req_cyc && full;
      if (m_show) begin
        m_show = 0;
      end else if (m_busy) begin
        if (ack_i || err_i || m_elapsed == TMO) begin
          m_busy = 0; m_show = 1;
          e_cyc = 1'b0; e_we = 1'b0;
          e_rtid = mcur.tid; e_radr = mcur.adr;
          if (ack_i && !err_i) begin
            e_ack  = 1'b1;
            e_rdat = mcur.we ? '0 : dat_i;
          end else begin
            e_err = 1'b1;
          end
        end else begin
          m_elapsed++;
        end
      end else if (mq.size() > 0) begin
        mcur = mq.pop_front();
        m_busy = 1; m_elapsed = 0;
        e_cyc = 1'b1; e_we = mcur.we;
      end
      if (bus.req_cyc && !full)
        mq.push_back({bus.req_we, bus.req_sel, bus.req_adr, bus.req_data1, bus.req_tid});
      e_stall = (mq.size() >= DEPTH - 1);
    end
  endtask

  task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp("wb_out", 256'({cyc_o, stb_o, we_o, sel_o, adr_o, dat_o}),
        256'({e_cyc, e_cyc, e_we, mcur.sel, mcur.adr, mcur.data}));
    cmp("resp_out", 256'({bus.resp_ack, bus.resp_err, bus.resp_rty, bus.resp_stall,
                          bus.resp_dat, bus.resp_tid, bus.resp_adr}),
        256'({e_ack, e_err, e_rty, e_stall, e_rdat, e_rtid, e_radr}));
  endtask

  typedef struct {
    bit             we;
    logic [SW-1:0]  sel;
    logic [31:0]    adr;
    logic [WID-1:0] wdata;
    logic [7:0]     tid;
    int             delay;
    bit             a, e;
    logic [WID-1:0] rdata;
    bit             x_ack, x_err;
    logic [WID-1:0] x_dat;
    int             x_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int  k, lat;
    bit  done;
    bus.req_cyc = 1'b1; bus.req_we = v.we; bus.req_sel = v.sel; bus.req_adr = v.adr;
    bus.req_data1 = v.wdata; bus.req_tid = v.tid;
    tick();
    bus.req_cyc = 1'b0;
    lat = 1; k = 0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.resp_ack || bus.resp_err) begin
        done = 1;
        cmp("vec_ack", 256'(bus.resp_ack), 256'(v.x_ack));
        cmp("vec_err", 256'(bus.resp_err), 256'(v.x_err));
        cmp("vec_dat", 256'(bus.resp_dat), 256'(v.x_dat));
        cmp("vec_tid_adr", 256'({bus.resp_tid, bus.resp_adr}), 256'({v.tid, v.adr}));
        cmp("vec_latency", 256'(lat), 256'(v.x_lat));
        cmp("vec_cyc_drop", 256'(cyc_o), 256'(0));
      end else begin
        ack_i = 1'b0; err_i = 1'b0;
        if (cyc_o) begin
          if (k == 0) cmp("vec_drive", 256'({we_o, sel_o, adr_o, dat_o}), 256'({v.we, v.sel, v.adr, v.wdata}));
          if (k == v.delay && (v.a || v.e)) begin
            ack_i = v.a; err_i = v.e; dat_i = v.rdata;
          end
          k++;
        end
        tick();
        lat++;
      end
    end
    if (!done) cmp("vec_resp_bound", 256'(0), 256'(1));
    ack_i = 1'b0; err_i = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] got[$];
    int         nresp, ncyc;

    rst = 1'b1; ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
    bus.req_cyc = 1'b0; bus.req_we = 1'b0; bus.req_sel = '0; bus.req_adr = '0;
    bus.req_data1 = '0; bus.req_tid = '0;
    tick(); tick();
    cmp("reset_state", 256'({cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, bus.resp_ack, bus.resp_err,
                             bus.resp_rty, bus.resp_stall, bus.resp_dat}), 256'(0));
    rst = 1'b0;
    tick();

    //           we  sel    adr           wdata       tid  dly a e  rdata       ack err x_dat  lat
    vecs[0] = '{1'b0, 8'h0F, 32'h0000_1000, 64'h0,      8'd5,  2, 1, 0, 64'hA5,     1, 0, 64'hA5, 5};
    vecs[1] = '{1'b1, 8'hFF, 32'h0000_2000, 64'h1234,   8'd6,  0, 1, 0, 64'hFFFF,   1, 0, 64'h0,  3};
    vecs[2] = '{1'b0, 8'h33, 32'h0000_3004, 64'h0,      8'd7,  1, 1, 1, 64'h55,     0, 1, 64'h0,  4};
    vecs[3] = '{1'b0, 8'hF0, 32'h0000_4008, 64'h0,      8'd8,  0, 0, 1, 64'h77,     0, 1, 64'h0,  3};
    vecs[4] = '{1'b0, 8'hFF, 32'h0000_5000, 64'h0,      8'd9,  0, 0, 0, 64'h0,      0, 1, 64'h0,  3 + TMO};
    vecs[5] = '{1'b1, 8'hC3, 32'h0000_6010, 64'hBEEF,   8'd10, 3, 1, 0, 64'h1111,   1, 0, 64'h0,  6};
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Backpressure: one cycle in flight, then five back-to-back requests with ack_i low.
    bus.req_we = 1'b0; bus.req_sel = '1; bus.req_adr = 32'h100; bus.req_tid = 8'h20;
    bus.req_cyc = 1'b1;
    tick();
    bus.req_cyc = 1'b0;
    for (int i = 0; i < 10 && !cyc_o; i++) tick();
    cmp("bp_busy", 256'(cyc_o), 256'(1));
    for (int r = 1; r <= 5; r++) begin
      bus.req_cyc = 1'b1; bus.req_tid = 8'(8'h20 + r); bus.req_adr = 32'(32'h100 + 4 * r);
      tick();
      if (r == 2) cmp("bp_stall_lo", 256'(bus.resp_stall), 256'(0));
      if (r == 3) cmp("bp_stall_hi", 256'(bus.resp_stall), 256'(1));
      cmp("bp_rty", 256'(bus.resp_rty), 256'(r == 5));
    end
    bus.req_cyc = 1'b0;
    tick();
    cmp("bp_rty_one", 256'(bus.resp_rty), 256'(0));
    ack_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.resp_ack) got.push_back(bus.resp_tid);
      tick();
    end
    ack_i = 1'b0;
    cmp("bp_count", 256'(got.size()), 256'(5));
    for (int j = 0; j < got.size() && j < 5; j++) cmp("bp_order", 256'(got[j]), 256'(8'h20 + j));

    // Reset in the middle of an access with two requests queued.
    bus.req_cyc = 1'b1; bus.req_tid = 8'h30;
    tick();
    bus.req_cyc = 1'b0;
    for (int i = 0; i < 10 && !cyc_o; i++) tick();
    bus.req_cyc = 1'b1; bus.req_tid = 8'h31; tick();
    bus.req_tid = 8'h32; tick();
    bus.req_cyc = 1'b0; tick();
    cmp("rst_pre_cyc", 256'(cyc_o), 256'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp("rst_cyc", 256'(cyc_o), 256'(0));
    cmp("rst_stall", 256'(bus.resp_stall), 256'(0));
    ack_i = 1'b1; nresp = 0; ncyc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.resp_ack || bus.resp_err) nresp++;
      if (cyc_o) ncyc++;
    end
    cmp("rst_no_resp", 256'(nresp), 256'(0));
    cmp("rst_fifo_empty", 256'(ncyc), 256'(0));

    // Random traffic against the model, including occasional resets and timeouts.
    for (int i = 0; i < 2000; i++) begin
      bus.req_cyc   = ($urandom_range(0, 2) == 0);
      bus.req_we    = 1'($urandom_range(0, 1));
      bus.req_sel   = SW'($urandom);
      bus.req_adr   = $urandom;
      bus.req_data1 = {$urandom, $urandom};
      bus.req_tid   = 8'($urandom);
      ack_i         = ($urandom_range(0, 4) == 0);
      err_i         = ($urandom_range(0, 11) == 0);
      dat_i         = {$urandom, $urandom};
      rst           = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fta_to_wb_bridge.md
FTA_TO_WB_BRIDGE -- requirements
Module: fta_to_wb_bridge

Interface
REQ-001 SHALL have parameter WID, default 256, data width of both buses.
REQ-002 SHALL have parameter DEPTH, default 4, request FIFO entries (power of two).
REQ-003 SHALL have parameter TMO, default 255, Wishbone timeout in clocks.
REQ-004 SHALL have port clk_i, input, 1, the only clock.
REQ-005 SHALL have port rst_i, input, 1, reset; synchronous to clk_i, active-high.
REQ-006 SHALL have port fta_i, fta_bus_interface.slave, FTA responder: req (cyc, we, sel, adr, data1, tid) in; resp (ack, err, rty, stall, dat, tid, adr) out.
REQ-007 SHALL have port cyc_o, output, 1, Wishbone cycle.
REQ-008 SHALL have port stb_o, output, 1, Wishbone strobe.
REQ-009 SHALL have port we_o, output, 1, Wishbone write enable.
REQ-010 SHALL have port sel_o, output, WID/8, byte selects.
REQ-011 SHALL have port adr_o, output, 32, address.
REQ-012 SHALL have port dat_o, output, WID, write data.
REQ-013 SHALL have port ack_i, input, 1, Wishbone acknowledge.
REQ-014 SHALL have port err_i, input, 1, Wishbone error.
REQ-015 SHALL have port dat_i, input, WID, read data.

Function
REQ-016 SHALL capture each clock with req.cyc=1 and FIFO not full into the FIFO: {we, sel, adr, data1, tid}.
REQ-017 SHALL drive resp.stall=1 while the FIFO holds DEPTH-1 or more entries, giving one slot of margin for a request already in flight.
REQ-018 SHALL drive resp.rty=1 for one clock, and drop the request, when req.cyc=1 arrives with the FIFO full.
REQ-019 SHALL run the Wishbone master FSM through IDLE, ACCESS and RESP.
- IDLE: on FIFO not empty, pop the head, drive cyc_o=stb_o=1 plus we_o/sel_o/adr_o/dat_o from the entry, then go to ACCESS.
- ACCESS: on ack_i or err_i, drop cyc_o/stb_o/we_o and latch dat_i, then go to RESP; hold all Wishbone outputs stable until then.
- RESP: drive the response for exactly one clock, then go to IDLE.
REQ-020 SHALL count ACCESS clocks in an 8-bit-minimum counter, cleared on entry; when it reaches TMO with no ack_i/err_i, end the cycle as an error and go to RESP.
REQ-021 SHALL, in RESP, pulse resp.ack=1 (ack_i) or resp.err=1 (err_i or timeout) with resp.tid and resp.adr from the entry; resp.dat is dat_i for reads, zero for writes and errors.
REQ-022 SHALL drive resp ack/err/rty to 0 and resp.dat to 0 in every clock where that signal is not pulsing.
REQ-023 SHALL respond to writes only after the Wishbone ack (no posted writes).
REQ-024 SHALL, when ack_i and err_i are both high, treat the termination as an error.
REQ-025 SHALL, when push and pop occur in the same clock, leave the count unchanged and keep both operations valid.
REQ-026 SHALL let FIFO pointers wrap modulo DEPTH.
REQ-027 SHALL keep at most one Wishbone cycle outstanding and issue responses in request order.
REQ-028 SHALL give a minimum latency of 3 clocks from accepted req.cyc to the response pulse when ack_i returns in the first ACCESS clock.

Reset
REQ-029 SHALL, on rst_i=1 at a clk_i edge, put the FSM in IDLE, empty the FIFO, clear the timeout counter, and zero cyc_o, stb_o, we_o, sel_o, adr_o, dat_o and every resp field.
REQ-030 SHALL, on reset during ACCESS, drop cyc_o on the next clock and discard all pending requests without responding.

Verification
REQ-031 SHALL verify single read: req adr=0x1000, tid=5; ack_i after 2 clocks with dat_i=0xA5 -> one resp.ack pulse, tid=5, dat=0xA5.
REQ-032 SHALL verify write: req we=1, sel=all ones, data1=0x1234; ack_i -> dat_o=0x1234 during the cycle, one ack pulse, resp.dat=0.
REQ-033 SHALL verify backpressure: 5 back-to-back requests with ack_i held low -> stall high after the 3rd is queued, 5th gets a rty pulse, responses for the first 4 arrive in tid order.
REQ-034 SHALL verify timeout: read with ack_i never asserted -> resp.err pulse exactly TMO+1 clocks after cyc_o rises, then cyc_o=0.
REQ-035 SHALL verify error: err_i together with ack_i -> resp.err=1, resp.ack=0.
REQ-036 SHALL verify reset: rst_i in mid-ACCESS with 2 requests queued -> cyc_o=0 next clock, no responses, FIFO empty, stall=0.
